word_packer: RTL and testbench

Upstream feeder for the command/data FIFO: accepts a narrow beat stream (valid/ready/last) and assembles beats into full-width words, zero-padding the final partial word of each packet. Completed words are emitted as a packed struct on a push/din/full interface that connects directly to the FIFO write port. It provides one beat per cycle sustained throughput when the FIFO is not full, and back-pressures the source otherwise.

---
 rtl/pack_pkg.sv | 13 +
 rtl/word_packer.sv | 81 ++++++++
 tb/tb_word_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pack_pkg.sv
// Shared widths and the FIFO word layout for the beat-to-word packer.
package pack_pkg;
  localparam int IN_W  = 8;
  localparam int LANES = 4;
  localparam int OUT_W = IN_W * LANES;
  localparam int CNT_W = $clog2(LANES + 1);

  typedef struct packed {
    logic             last;
    logic [CNT_W-1:0] nbytes;
    logic [OUT_W-1:0] data;
  } pack_word_t;
endpackage

// File: rtl/word_packer.sv
// Packs IN_W-bit beats into LANES-wide words, zero-padding the tail of each
// packet, and presents each finished word on a FIFO push/din/full port.
module word_packer #(
  parameter  int IN_W  = pack_pkg::IN_W,
  parameter  int LANES = pack_pkg::LANES,
  localparam int OUT_W = IN_W * LANES,
  localparam int CNT_W = $clog2(LANES + 1),
  localparam int DW    = 1 + CNT_W + OUT_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            push,
  output logic [DW-1:0]   din,
  input  logic            full
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                       state;
  logic [LW-1:0]                    lane;
  logic [LANES-1:0][IN_W-1:0]       acc;
  logic [LANES-1:0][IN_W-1:0]       nxt;
  logic                             o_last;
  logic [CNT_W-1:0]                 o_nbytes;
  logic [OUT_W-1:0]                 o_data;
  logic                             beat;
  logic                             done;
  logic [LW-1:0]                    wr_lane;

  assign in_ready = (state == FILL) || !full;
  assign push     = (state == HOLD) && !full;
  assign beat     = in_valid && in_ready;
  // A beat accepted while a word is held always opens a fresh word.
  assign wr_lane  = (state == HOLD) ? '0 : lane;
  assign done     = beat && (in_last || (wr_lane == LW'(LANES - 1)));
  assign din      = {o_last, o_nbytes, o_data};

  // Completed word: earlier lanes from the accumulator, current beat, zeros above.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LW'(i) < wr_lane)       nxt[i] = acc[i];
      else if (LW'(i) == wr_lane) nxt[i] = in_data;
      else                        nxt[i] = '0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    always_ff @(posedge clk) begin
      if (!rstn)                             acc[g] <= '0;
      else if (beat && (wr_lane == LW'(g)))  acc[g] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= FILL;
      lane     <= '0;
      o_last   <= 1'b0;
      o_nbytes <= '0;
      o_data   <= '0;
    end else if (done) begin
      state    <= HOLD;
      lane     <= '0;
      o_last   <= in_last;
      o_nbytes <= CNT_W'(wr_lane) + CNT_W'(1);
      o_data   <= nxt;
    end else if (beat) begin
      state    <= FILL;
      lane     <= wr_lane + LW'(1);
    end else if (push) begin
      state    <= FILL;
      lane     <= '0;
    end
  end
endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench: a packet-level model predicts each FIFO word; a negedge
// monitor checks handshake outputs and popped words against it.
module tb_word_packer;
  import pack_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             push;
  logic [$bits(pack_word_t)-1:0] din;
  logic             full = 1'b0;

  word_packer dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .push(push), .din(din), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { pack_word_t w; int done; } exp_t;
  exp_t             expq[$];
  logic [IN_W-1:0]  part[$];
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               lat_chk = 1'b0;
  bit               was_rst = 1'b0;
  bit               rnd_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Monitor and reference model.
  always @(negedge clk) begin
    bit held;
    pack_word_t w;
    if (was_rst) begin
      chk("rst_din", din, 0);
      chk("rst_push", push, 0);
      chk("rst_ready", in_ready, 1);
    end
    held = (expq.size() > 0) && (expq[0].done < cyc);
    chk("push", push, held && !full);
    chk("in_ready", in_ready, !held || !full);
    if (held) chk("din", din, expq[0].w);
    if (push && held) begin
      if (lat_chk) chk("latency", cyc, expq[0].done + 1);
      void'(expq.pop_front());
    end
    if (!rstn) begin
      expq.delete();
      part.delete();
    end else if (in_valid && in_ready) begin
      part.push_back(in_data);
      if (in_last || part.size() == LANES) begin
        w = '0;
        foreach (part[i]) w.data[i*IN_W +: IN_W] = part[i];
        w.nbytes = CNT_W'(part.size());
        w.last   = in_last;
        expq.push_back('{w: w, done: cyc});
        part.delete();
      end
    end
    was_rst = !rstn;
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_full) full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    bit ok;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk); ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: beat %0h not accepted, want accept within 200", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() > 0) && n < 500) begin tick(); n++; end
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] b;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    lat_chk = 1'b1;
    // Full word, then partial word.
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    drain();
    send(8'hAA, 0); send(8'hBB, 1);
    drain();
    // Streaming 12 beats back to back.
    for (int i = 0; i < 12; i++) send(IN_W'(i), i == 11);
    drain();
    // Single-beat packets.
    send(8'h5A, 1); send(8'h5B, 1);
    drain();
    // Back-pressure: full raised before the first word completes.
    lat_chk = 1'b0;
    full = 1'b1;
    fork
      for (int i = 0; i < 8; i++) send(8'hC0 + IN_W'(i), i == 7);
      begin repeat (12) tick(); full = 1'b0; end
    join
    drain();
    // Reset mid-word discards the partial word.
    lat_chk = 1'b1;
    send(8'h01, 0); send(8'h02, 0);
    rstn = 1'b0; tick(); rstn = 1'b1;
    send(8'h10, 0); send(8'h11, 0); send(8'h12, 0); send(8'h13, 1);
    drain();
    // Randomized packets with random gaps and FIFO back-pressure.
    lat_chk = 1'b0;
    rnd_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = IN_W'($urandom);
      send(b, (i == 299) || ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rnd_full = 1'b0; full = 1'b0;
    drain();
    chk("partial_left", part.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
